// File: rtl/pomodoro_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pomodoro_timer_ctrl
// Description : Countdown timer with four presets, pause/resume, automatic
//               reload, a saturating session counter, BCD readout and a
//               ready/valid frame stream for a 74HC595 display driver.
// Revision    : 1.0 - initial release
// ============================================================================
module pomodoro_timer_ctrl #(
    parameter int TICK_LIM = 125000000,
    parameter int T0       = 3000,
    parameter int T1       = 1500,
    parameter int T2       = 600,
    parameter int T3       = 300,
    parameter int SESS_MAX = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  btn_sel,
    input  logic        btn_pause,
    input  logic        auto_mode,
    output logic [1:0]  state,
    output logic        done_pulse,
    output logic [13:0] sess_cnt,
    output logic [31:0] digits,
    output logic [15:0] out_dat,
    output logic        out_vld,
    input  logic        out_rdy
);

    // Parameter range guard: an illegal configuration stops elaboration.
    if (TICK_LIM < 2 || SESS_MAX < 0 || SESS_MAX > 9999 ||
        T0 < 1 || T0 > 5999 || T1 < 1 || T1 > 5999 ||
        T2 < 1 || T2 > 5999 || T3 < 1 || T3 > 5999) begin : g_param_err
        $error("pomodoro_timer_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int              c_pw       = (TICK_LIM > 1) ? $clog2(TICK_LIM) : 1;
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(TICK_LIM - 1);
    localparam logic [12:0]     c_t0       = 13'(T0);
    localparam logic [12:0]     c_t1       = 13'(T1);
    localparam logic [12:0]     c_t2       = 13'(T2);
    localparam logic [12:0]     c_t3       = 13'(T3);
    localparam logic [13:0]     c_sess_max = 14'(SESS_MAX);

    state_t          r_state, w_state_nxt;
    logic [12:0]     r_rem, w_rem_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic [c_pw-1:0] r_pre, w_pre_nxt;
    logic [13:0]     r_sess, w_sess_nxt;
    logic            r_done, w_done_nxt;
    logic [3:0]      r_sel_prev;
    logic            r_pause_prev;
    logic [31:0]     r_digits;
    logic [2:0]      r_scan;
    logic [15:0]     r_out_dat;
    logic            r_out_vld;

    logic [3:0]      w_sel_edge;
    logic            w_pause_edge;
    logic            w_load;
    logic [1:0]      w_load_idx;
    logic            w_tick;
    logic            w_xfer;
    logic [2:0]      w_scan_nxt;
    logic [3:0]      w_digit_nxt;
    logic [15:0]     w_frame_nxt;

    // Preset duration lookup by index.
    function automatic logic [12:0] f_preset(input logic [1:0] idx);
        case (idx)
            2'd0:    f_preset = c_t0;
            2'd1:    f_preset = c_t1;
            2'd2:    f_preset = c_t2;
            default: f_preset = c_t3;
        endcase
    endfunction

    // Remaining seconds as MM:SS and the session count as four decimal digits.
    function automatic logic [31:0] f_digits(input logic [12:0] rem, input logic [13:0] sess);
        logic [12:0] mins;
        logic [12:0] secs;
        mins = rem / 13'd60;
        secs = rem % 13'd60;
        f_digits = {4'(mins / 13'd10), 4'(mins % 13'd10),
                    4'(secs / 13'd10), 4'(secs % 13'd10),
                    4'(sess / 14'd1000), 4'((sess / 14'd100) % 14'd10),
                    4'((sess / 14'd10) % 14'd10), 4'(sess % 14'd10)};
    endfunction

    // Active-low {dp,g..a} pattern; the decimal point is always off.
    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 8'hC0;
            4'd1:    f_seg = 8'hF9;
            4'd2:    f_seg = 8'hA4;
            4'd3:    f_seg = 8'hB0;
            4'd4:    f_seg = 8'h99;
            4'd5:    f_seg = 8'h92;
            4'd6:    f_seg = 8'h82;
            4'd7:    f_seg = 8'hF8;
            4'd8:    f_seg = 8'h80;
            4'd9:    f_seg = 8'h90;
            default: f_seg = 8'hFF;
        endcase
    endfunction

    assign w_sel_edge   = btn_sel & ~r_sel_prev;
    assign w_pause_edge = btn_pause & ~r_pause_prev;
    assign w_load       = |w_sel_edge;
    assign w_tick       = (r_state == ST_RUN) && (r_pre == c_pre_last);

    // Lowest-numbered preset button wins when several rise together.
    always_comb begin
        w_load_idx = 2'd0;
        if (w_sel_edge[0])      w_load_idx = 2'd0;
        else if (w_sel_edge[1]) w_load_idx = 2'd1;
        else if (w_sel_edge[2]) w_load_idx = 2'd2;
        else if (w_sel_edge[3]) w_load_idx = 2'd3;
    end

    // Next-state logic: preset load beats everything, expiry beats pause.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_idx_nxt   = r_idx;
        w_pre_nxt   = r_pre;
        w_sess_nxt  = r_sess;
        w_done_nxt  = 1'b0;
        if (w_load) begin
            w_state_nxt = ST_RUN;
            w_rem_nxt   = f_preset(w_load_idx);
            w_idx_nxt   = w_load_idx;
            w_pre_nxt   = '0;
            if (w_load_idx != r_idx) begin
                w_sess_nxt = 14'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
                    if (w_tick && r_rem == 13'd1) begin
                        w_rem_nxt   = 13'd0;
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        if (r_sess < c_sess_max) begin
                            w_sess_nxt = r_sess + 14'd1;
                        end
                    end else begin
                        if (w_tick) begin
                            w_rem_nxt = r_rem - 13'd1;
                        end
                        if (w_pause_edge) begin
                            w_state_nxt = ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_pause_edge) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (auto_mode) begin
                        w_state_nxt = ST_RUN;
                        w_rem_nxt   = f_preset(r_idx);
                        w_pre_nxt   = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timer state register and button history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rem        <= 13'd0;
            r_idx        <= 2'd0;
            r_pre        <= '0;
            r_sess       <= 14'd0;
            r_done       <= 1'b0;
            r_sel_prev   <= 4'd0;
            r_pause_prev <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem_nxt;
            r_idx        <= w_idx_nxt;
            r_pre        <= w_pre_nxt;
            r_sess       <= w_sess_nxt;
            r_done       <= w_done_nxt;
            r_sel_prev   <= btn_sel;
            r_pause_prev <= btn_pause;
        end
    end

    // Registered BCD readout, one cycle behind the timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 32'd0;
        end else begin
            r_digits <= f_digits(r_rem, r_sess);
        end
    end

    assign w_xfer      = r_out_vld && out_rdy;
    assign w_scan_nxt  = r_scan + 3'd1;
    assign w_digit_nxt = r_digits[{w_scan_nxt, 2'b00} +: 4];
    assign w_frame_nxt = {f_seg(w_digit_nxt), 8'h01 << w_scan_nxt};

    // Display stream: the frame advances only after the controller takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan    <= 3'd0;
            r_out_dat <= 16'hC001;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= 1'b1;
            if (w_xfer) begin
                r_scan    <= w_scan_nxt;
                r_out_dat <= w_frame_nxt;
            end
        end
    end

    assign state      = r_state;
    assign done_pulse = r_done;
    assign sess_cnt   = r_sess;
    assign digits     = r_digits;
    assign out_dat    = r_out_dat;
    assign out_vld    = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_pomodoro_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pomodoro_timer_ctrl
// Description : Self-checking bench for pomodoro_timer_ctrl with directed
//               scenarios and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pomodoro_timer_ctrl;

    localparam int c_tick = 4;
    localparam int c_smax = 12;
    localparam int c_idle = 0;
    localparam int c_run  = 1;
    localparam int c_paus = 2;
    localparam int c_done = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn_sel = 4'd0;
    logic        btn_pause = 1'b0;
    logic        auto_mode = 1'b0;
    logic [1:0]  state;
    logic        done_pulse;
    logic [13:0] sess_cnt;
    logic [31:0] digits;
    logic [15:0] out_dat;
    logic        out_vld;
    logic        out_rdy = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    pomodoro_timer_ctrl #(
        .TICK_LIM (c_tick),
        .T0       (3),
        .T1       (2),
        .T2       (61),
        .T3       (5999),
        .SESS_MAX (c_smax)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_sel    (btn_sel),
        .btn_pause  (btn_pause),
        .auto_mode  (auto_mode),
        .state      (state),
        .done_pulse (done_pulse),
        .sess_cnt   (sess_cnt),
        .digits     (digits),
        .out_dat    (out_dat),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (seconds + cycle fraction) -----------
    int          tset [4] = '{3, 2, 61, 5999};
    logic [7:0]  seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    int          m_st, m_rem, m_frac, m_idx, m_sess, m_scan;
    logic        m_done, m_vld, m_pause_prev;
    logic [3:0]  m_sel_prev;
    logic [31:0] m_digits;
    logic [15:0] m_dat;

    function automatic logic [31:0] fmt(int rem, int sess);
        int mi;
        int se;
        mi = rem / 60;
        se = rem % 60;
        return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10),
                4'(sess / 1000), 4'((sess / 100) % 10), 4'((sess / 10) % 10), 4'(sess % 10)};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int st, rem, frac, idx, sess, scan, li;
        logic [3:0]  e;
        logic        pe, dn;
        logic [15:0] dat;
        if (!rst_n) begin
            m_st <= c_idle; m_rem <= 0; m_frac <= 0; m_idx <= 0; m_sess <= 0;
            m_scan <= 0; m_done <= 1'b0; m_vld <= 1'b0; m_pause_prev <= 1'b0;
            m_sel_prev <= 4'd0; m_digits <= 32'd0; m_dat <= 16'hC001;
        end else begin
            st = m_st; rem = m_rem; frac = m_frac; idx = m_idx; sess = m_sess;
            scan = m_scan; dat = m_dat; dn = 1'b0; li = 0;
            e  = btn_sel & ~m_sel_prev;
            pe = btn_pause & ~m_pause_prev;
            if (m_vld && out_rdy) begin
                scan = (scan + 1) % 8;
                dat  = {seg_tab[m_digits[scan*4 +: 4]], 8'h01 << scan};
            end
            for (int i = 3; i >= 0; i--) if (e[i]) li = i;
            if (e != 4'd0) begin
                if (li != idx) sess = 0;
                idx = li; rem = tset[li]; frac = 0; st = c_run;
            end else if (st == c_run) begin
                if (frac == c_tick - 1) begin
                    frac = 0;
                    rem  = rem - 1;
                    if (rem == 0) begin
                        st = c_done; dn = 1'b1;
                        if (sess < c_smax) sess = sess + 1;
                    end
                end else begin
                    frac = frac + 1;
                end
                if (pe && st == c_run) st = c_paus;
            end else if (st == c_paus) begin
                if (pe) st = c_run;
            end else if (st == c_done && auto_mode) begin
                rem = tset[idx]; frac = 0; st = c_run;
            end
            m_digits <= fmt(m_rem, m_sess);
            m_st <= st; m_rem <= rem; m_frac <= frac; m_idx <= idx; m_sess <= sess;
            m_scan <= scan; m_dat <= dat; m_done <= dn; m_vld <= 1'b1;
            m_sel_prev <= btn_sel; m_pause_prev <= btn_pause;
        end
    end

    // ---------------- directed scenarios -----------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({state, done_pulse, sess_cnt, digits, out_vld} !== 50'd0)
            $display("FAIL reset_regs: got st=%0d dn=%0b sess=%0d dig=%h vld=%0b required all zero",
                     state, done_pulse, sess_cnt, digits, out_vld);
        else n_pass++;
        n_checks++;
        if (out_dat !== 16'hC001) $display("FAIL reset_dat: got %h required c001", out_dat);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_vld !== 1'b1 || out_dat !== 16'hC001 || state !== 2'd0 || digits !== 32'd0)
            $display("FAIL release: got vld=%0b dat=%h st=%0d dig=%h required 1 c001 0 0",
                     out_vld, out_dat, state, digits);
        else n_pass++;
    endtask

    task automatic test_run_expire();
        int done_at = -1;
        int pulses  = 0;
        btn_sel = 4'b0001;
        @(negedge clk);
        btn_sel = 4'b0000;
        n_checks++;
        if (state !== 2'd1) $display("FAIL run_enter: got %0d required 1", state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (digits[31:16] !== 16'h0003) $display("FAIL run_digits: got %h required 0003", digits[31:16]);
        else n_pass++;
        if (done_pulse) pulses++;
        for (int k = 2; k <= 13; k++) begin
            @(negedge clk);
            if (done_pulse) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k == 12) begin
                n_checks++;
                if (state !== 2'd3 || sess_cnt !== 14'd1)
                    $display("FAIL expire_state: got st=%0d sess=%0d required 3 1", state, sess_cnt);
                else n_pass++;
            end
        end
        n_checks++;
        if (done_at !== 12 || pulses !== 1)
            $display("FAIL expire_time: got cycle %0d pulses %0d required 12 1", done_at, pulses);
        else n_pass++;
        n_checks++;
        if (digits[15:0] !== 16'h0001) $display("FAIL sess_digits: got %h required 0001", digits[15:0]);
        else n_pass++;
    endtask

    task automatic test_pause();
        int done_at = -1;
        btn_sel = 4'b0001;
        @(negedge clk);
        btn_sel = 4'b0000;
        for (int k = 1; k <= 40; k++) begin
            btn_pause = (k == 5 || k == 25);
            @(negedge clk);
            if (done_pulse && done_at < 0) done_at = k;
            if (k == 8 || k == 20 || k == 24) begin
                n_checks++;
                if (state !== 2'd2 || digits[31:16] !== 16'h0002)
                    $display("FAIL pause_hold_%0d: got st=%0d mmss=%h required 2 0002", k, state, digits[31:16]);
                else n_pass++;
            end
        end
        btn_pause = 1'b0;
        n_checks++;
        if (done_at !== 32) $display("FAIL pause_expire: got cycle %0d required 32", done_at);
        else n_pass++;
        n_checks++;
        if (sess_cnt !== 14'd2) $display("FAIL rerun_sess: got %0d required 2", sess_cnt);
        else n_pass++;
    endtask

    task automatic test_presets();
        btn_sel = 4'b0010;
        @(negedge clk);
        btn_sel = 4'b0000;
        n_checks++;
        if (sess_cnt !== 14'd0 || state !== 2'd1)
            $display("FAIL preset1: got sess=%0d st=%0d required 0 1", sess_cnt, state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (digits[31:16] !== 16'h0002) $display("FAIL preset1_digits: got %h required 0002", digits[31:16]);
        else n_pass++;
        btn_sel = 4'b0011;
        btn_pause = 1'b1;
        @(negedge clk);
        btn_sel = 4'b0000;
        btn_pause = 1'b0;
        n_checks++;
        if (state !== 2'd1) $display("FAIL preset_over_pause: got %0d required 1", state);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (digits[31:16] !== 16'h0003) $display("FAIL lowest_wins: got %h required 0003", digits[31:16]);
        else n_pass++;
        btn_sel = 4'b0100;
        @(negedge clk);
        btn_sel = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (digits[31:16] !== 16'h0101) $display("FAIL preset2_digits: got %h required 0101", digits[31:16]);
        else n_pass++;
        btn_sel = 4'b1000;
        @(negedge clk);
        btn_sel = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (digits[31:16] !== 16'h9959) $display("FAIL preset3_digits: got %h required 9959", digits[31:16]);
        else n_pass++;
    endtask

    task automatic test_auto();
        int done_at = -1;
        int pulses  = 0;
        auto_mode = 1'b1;
        btn_sel = 4'b0001;
        @(negedge clk);
        btn_sel = 4'b0000;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done_pulse) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k == 12) begin
                n_checks++;
                if (state !== 2'd3) $display("FAIL auto_done: got %0d required 3", state);
                else n_pass++;
            end
            if (k == 13) begin
                n_checks++;
                if (state !== 2'd1 || done_pulse !== 1'b0)
                    $display("FAIL auto_reload: got st=%0d dn=%0b required 1 0", state, done_pulse);
                else n_pass++;
            end
            if (k == 14) begin
                n_checks++;
                if (digits[31:16] !== 16'h0003) $display("FAIL auto_rem: got %h required 0003", digits[31:16]);
                else n_pass++;
            end
        end
        auto_mode = 1'b0;
        n_checks++;
        if (done_at !== 12 || pulses !== 15)
            $display("FAIL auto_period: got first %0d pulses %0d required 12 15", done_at, pulses);
        else n_pass++;
        n_checks++;
        if (sess_cnt !== 14'd12 || digits[15:0] !== 16'h0012)
            $display("FAIL sess_sat: got %0d digits %h required 12 0012", sess_cnt, digits[15:0]);
        else n_pass++;
    endtask

    task automatic test_stream();
        n_checks++;
        if (out_dat[7:0] !== 8'h01) $display("FAIL stream_start: got %h required 01", out_dat[7:0]);
        else n_pass++;
        out_rdy = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_dat[7:0] !== (8'h01 << (j % 8)) || out_dat !== m_dat)
                $display("FAIL stream_sel_%0d: got %h required sel %h frame %h",
                         j, out_dat, 8'h01 << (j % 8), m_dat);
            else n_pass++;
        end
        out_rdy = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            n_checks++;
            if (out_dat[7:0] !== 8'h02 || out_dat !== m_dat)
                $display("FAIL stream_hold_%0d: got %h required %h", j, out_dat, m_dat);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        btn_sel = 4'b0010;
        @(negedge clk);
        btn_sel = 4'b0000;
        out_rdy = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state, done_pulse, sess_cnt, digits, out_vld} !== 50'd0 || out_dat !== 16'hC001)
            $display("FAIL async_reset: got st=%0d sess=%0d dig=%h vld=%0b dat=%h required reset values",
                     state, sess_cnt, digits, out_vld, out_dat);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_vld !== 1'b1 || out_dat !== 16'hC001 || state !== 2'd0)
            $display("FAIL mid_release: got vld=%0b dat=%h st=%0d required 1 c001 0", out_vld, out_dat, state);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [65:0] act;
        logic [65:0] exp_v;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            act   = {state, done_pulse, sess_cnt, digits, out_dat, out_vld};
            exp_v = {2'(m_st), m_done, 14'(m_sess), m_digits, m_dat, m_vld};
            n_checks++;
            if (act !== exp_v) $display("FAIL random_%0d: got %h required %h", c, act, exp_v);
            else n_pass++;
            if ($urandom_range(0, 59) == 0) btn_sel = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) btn_sel = 4'd0;
            if ($urandom_range(0, 9) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 199) == 0) auto_mode = ~auto_mode;
            out_rdy = ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_run_expire();
        test_pause();
        test_presets();
        test_auto();
        test_stream();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
